// File: rtl/mp_add_sequencer_pkg.sv
// Shared types and sizing helpers for the multi-precision add sequencer.
// The optional signed-overflow output is enabled with the MPADD_OVF_EN macro
// (see mp_add_sequencer.sv).
package mp_add_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    // Width of the word index: $clog2(words), never less than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // Width of the wait counter, which holds values up to lat-1.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

    // Sizing for the default configuration (WORDS=4, ADD_LAT=0).
    localparam int DEF_WORDS   = 4;
    localparam int DEF_ADD_LAT = 0;
    localparam int DEF_IDX_W   = idx_width(DEF_WORDS);
    localparam int DEF_CNT_W   = cnt_width(DEF_ADD_LAT);

endpackage

// File: rtl/mp_add_sequencer.sv
// Multi-precision add controller. Feeds an external WIDTH-bit adder one word
// pair at a time (LSW first), chains the carry between words and registers
// the wide sum and final carry before pulsing done.
// Optional feature: define MPADD_OVF_EN to add the signed-overflow output ovf.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [WIDTH*WORDS-1:0]   opa,
    input  logic [WIDTH*WORDS-1:0]   opb,
    input  logic                     cin_in,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH*WORDS-1:0]   sum,
    output logic                     cout_out,
`ifdef MPADD_OVF_EN
    output logic                     ovf,
`endif
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_s,
    input  logic                     add_cout
);

    localparam int IW = idx_width(WORDS);
    localparam int CW = cnt_width(ADD_LAT);

    state_t                          state;
    logic [IW-1:0]                   idx;
    logic [CW-1:0]                   cnt;
    logic                            carry;
    logic [WORDS-1:0][WIDTH-1:0]     a_reg;
    logic [WORDS-1:0][WIDTH-1:0]     b_reg;
    logic [WORDS-1:0][WIDTH-1:0]     work;

    logic [WORDS-1:0][WIDTH-1:0]     work_next;
    logic [IW-1:0]                   idx_next;
    logic                            last;
    logic                            capture;

    // Adder result is taken this cycle: immediately in ISSUE for a
    // combinational adder, otherwise when the wait counter runs out.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        work_next      = work;
        work_next[idx] = add_s;
        idx_next       = idx + 1'b1;
        last           = (idx == IW'(WORDS - 1));
        capture        = ((state == ISSUE) && (ADD_LAT == 0)) ||
                         ((state == WAIT) && (cnt == '0));
    end

    // Controller FSM; all outputs are registered and loaded one edge ahead
    // so they are valid for the whole cycle of the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            work     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout_out <= 1'b0;
`ifdef MPADD_OVF_EN
            ovf      <= 1'b0;
`endif
            add_a    <= '0;
            add_b    <= '0;
            add_cin  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= opa;
                        b_reg   <= opb;
                        carry   <= cin_in;
                        idx     <= '0;
                        add_a   <= opa[WIDTH-1:0];
                        add_b   <= opb[WIDTH-1:0];
                        add_cin <= cin_in;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (capture) begin
                        work  <= work_next;
                        carry <= add_cout;
                        if (last) begin
                            sum      <= work_next;
                            cout_out <= add_cout;
                            done     <= 1'b1;
`ifdef MPADD_OVF_EN
                            ovf      <= (a_reg[WORDS-1][WIDTH-1] == b_reg[WORDS-1][WIDTH-1]) &&
                                        (add_s[WIDTH-1] != a_reg[WORDS-1][WIDTH-1]);
`endif
                            add_a    <= '0;
                            add_b    <= '0;
                            add_cin  <= 1'b0;
                            state    <= FINISH;
                        end else begin
                            idx     <= idx_next;
                            add_a   <= a_reg[idx_next];
                            add_b   <= b_reg[idx_next];
                            add_cin <= add_cout;
                            state   <= ISSUE;
                        end
                    end else if (state == ISSUE) begin
                        cnt   <= CW'(ADD_LAT - 1);
                        state <= WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer: three instances (WORDS=2/ADD_LAT=0,
// WORDS=2/ADD_LAT=2, WORDS=4/ADD_LAT=1) each looped back to a behavioural adder.
module tb_mp_add_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic         rst0, rst2, rst4;
    logic         start0, start2, start4;
    logic [127:0] opa, opb;
    logic         cin;

    // Instance 0: WORDS=2, ADD_LAT=0
    logic busy0, done0, cout0, add_cin0, add_cout0;
    logic [63:0] sum0;
    logic [31:0] add_a0, add_b0, add_s0;
    // Instance 2: WORDS=2, ADD_LAT=2
    logic busy2, done2, cout2, add_cin2, add_cout2;
    logic [63:0] sum2;
    logic [31:0] add_a2, add_b2, add_s2;
    logic [32:0] pipe2_a, pipe2_b;
    // Instance 4: WORDS=4, ADD_LAT=1
    logic busy4, done4, cout4, add_cin4, add_cout4;
    logic [127:0] sum4;
    logic [31:0] add_a4, add_b4, add_s4;
    logic [32:0] pipe4;
`ifdef MPADD_OVF_EN
    logic ovf0, ovf2, ovf4;
`endif

    // Behavioural adders
    assign {add_cout0, add_s0} = 33'(add_a0) + 33'(add_b0) + 33'(add_cin0);
    always @(posedge clk) begin
        pipe2_a <= 33'(add_a2) + 33'(add_b2) + 33'(add_cin2);
        pipe2_b <= pipe2_a;
        pipe4   <= 33'(add_a4) + 33'(add_b4) + 33'(add_cin4);
    end
    assign {add_cout2, add_s2} = pipe2_b;
    assign {add_cout4, add_s4} = pipe4;

    mp_add_sequencer #(.WIDTH(32), .WORDS(2), .ADD_LAT(0)) u0 (
        .clk(clk), .rst(rst0), .start(start0), .opa(opa[63:0]), .opb(opb[63:0]),
        .cin_in(cin), .busy(busy0), .done(done0), .sum(sum0), .cout_out(cout0),
`ifdef MPADD_OVF_EN
        .ovf(ovf0),
`endif
        .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0),
        .add_s(add_s0), .add_cout(add_cout0)
    );

    mp_add_sequencer #(.WIDTH(32), .WORDS(2), .ADD_LAT(2)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .opa(opa[63:0]), .opb(opb[63:0]),
        .cin_in(cin), .busy(busy2), .done(done2), .sum(sum2), .cout_out(cout2),
`ifdef MPADD_OVF_EN
        .ovf(ovf2),
`endif
        .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
        .add_s(add_s2), .add_cout(add_cout2)
    );

    mp_add_sequencer #(.WIDTH(32), .WORDS(4), .ADD_LAT(1)) u4 (
        .clk(clk), .rst(rst4), .start(start4), .opa(opa), .opb(opb),
        .cin_in(cin), .busy(busy4), .done(done4), .sum(sum4), .cout_out(cout4),
`ifdef MPADD_OVF_EN
        .ovf(ovf4),
`endif
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_s(add_s4), .add_cout(add_cout4)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start one op on instance 0, check busy, latency and result.
    task automatic run0(input vec_t v);
        int cyc;
        @(negedge clk);
        opa = {64'h0, v.a}; opb = {64'h0, v.b}; cin = v.ci; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 1;
        check("busy0_after_start", busy0, 1'b1);
        while (!done0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("lat0", cyc, 3);
        check("sum0", sum0, v.s);
        check("cout0", cout0, v.co);
        check("busy0_at_done", busy0, 1'b1);
`ifdef MPADD_OVF_EN
        check("ovf0", ovf0, v.ov);
`endif
        @(negedge clk);
        check("done0_pulse_width", done0, 1'b0);
    endtask

    initial begin
        int cyc;
        int n_done;

        vecs[0] = '{64'h0000_0000_7FFF_FFFF, 64'h1, 1'b0, 64'h0000_0000_8000_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[4] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0001_FFFF_FFFF, 1'b1, 64'h0000_0001_0000_0000, 1'b1, 1'b0};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0};

        rst0 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
        start0 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        opa = '0; opb = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_sum", sum0, 64'h0);
        check("rst_cout", cout0, 1'b0);
        check("rst_add_a", add_a0, 32'h0);
        check("rst_add_b", add_b0, 32'h0);
        check("rst_add_cin", add_cin0, 1'b0);
        rst0 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;

        // Table-driven vectors on the combinational-adder instance
        for (int i = 0; i < 6; i++) run0(vecs[i]);

        // Second start while busy and start in the done cycle are both ignored
        @(negedge clk);
        opa = {64'h0, vecs[5].a}; opb = {64'h0, vecs[5].b}; cin = 1'b0; start0 = 1'b1;
        @(negedge clk);
        opa = {64'h0, vecs[1].a}; opb = {64'h0, vecs[1].b};
        @(negedge clk);
        start0 = 1'b0;
        cyc = 2;
        while (!done0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("ign_lat", cyc, 3);
        check("ign_sum", sum0, vecs[5].s);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("ign_done_cycle_start", busy0, 1'b0);
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (done0) n_done++;
        end
        check("ign_no_extra_done", n_done, 0);
        check("ign_sum_held", sum0, vecs[5].s);
        run0(vecs[0]);

        // ADD_LAT=2 with adder inputs held through each WAIT
        @(negedge clk);
        opa = {64'h0, 64'h0000_0001_0000_0001}; opb = {64'h0, 64'h0000_0000_FFFF_FFFF};
        cin = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        opa = '0; opb = '0;
        cyc = 1;
        while (!done2 && cyc < 60) begin
            if (cyc <= 3) begin
                check("lat2_a_w0", add_a2, 32'h0000_0001);
                check("lat2_b_w0", add_b2, 32'hFFFF_FFFF);
                check("lat2_cin_w0", add_cin2, 1'b0);
            end else begin
                check("lat2_a_w1", add_a2, 32'h0000_0001);
                check("lat2_b_w1", add_b2, 32'h0000_0000);
                check("lat2_cin_w1", add_cin2, 1'b1);
            end
            @(negedge clk);
            cyc++;
        end
        check("lat2_latency", cyc, 7);
        check("lat2_sum", sum2, 64'h0000_0002_0000_0000);
        check("lat2_cout", cout2, 1'b0);

        // WORDS=4, ADD_LAT=1: normal op, then reset mid-op, then a fresh op
        @(negedge clk);
        opa = 128'h0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; opb = 128'h1; cin = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 1;
        while (!done4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("w4_latency", cyc, 9);
        check("w4_sum", sum4, 128'h0000_0002_0000_0000_0000_0000_0000_0000);
        check("w4_cout", cout4, 1'b0);

        @(negedge clk);
        opa = 128'h5; opb = 128'h7; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        check("rst_mid_busy", busy4, 1'b0);
        check("rst_mid_sum", sum4, 128'h0);
        check("rst_mid_cout", cout4, 1'b0);
        check("rst_mid_add_a", add_a4, 32'h0);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done4) n_done++;
        end
        check("rst_mid_no_done", n_done, 0);

        opa = {128{1'b1}}; opb = 128'h1; cin = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 1;
        while (!done4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("w4b_latency", cyc, 9);
        check("w4b_sum", sum4, 128'h1);
        check("w4b_cout", cout4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
